// File: rtl/cube_shift_pkg.sv
// Shared types and sizing helpers for the LED-cube 74HC595 frame shifter.
package cube_shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH,
        ST_DWELL
    } shift_state_t;

    localparam int unsigned DEF_CTRL_BITS   = 56;
    localparam int unsigned DEF_COLOR_BITS  = 8;
    localparam int unsigned DEF_HALF_PERIOD = 4;
    localparam int unsigned DEF_DWELL       = 1000;
    localparam int unsigned DEF_CNT_WIDTH   = 16;

    function automatic int unsigned slot_len(input int unsigned half_period);
        return 2 * half_period;
    endfunction

    // Colour chains are right-aligned against the control chain.
    function automatic int unsigned color_start(input int unsigned ctrl_bits,
                                                input int unsigned color_bits);
        return ctrl_bits - color_bits;
    endfunction

endpackage

// File: rtl/cube_frame_shifter_shift_lane.sv
// Parallel-load, MSB-first shift register feeding one 74HC595 serial input.
module shift_lane #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_msb
);

    logic [WIDTH-1:0] r_sr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= i_data;
        end else if (i_shift) begin
            r_sr <= r_sr << 1;
        end
    end

    assign o_msb = r_sr[WIDTH-1];

endmodule

// File: rtl/cube_frame_shifter.sv
// Serialises one plane frame onto the control and RGB '595 chains, latches it, then dwells.
// Optional active-low output enable OE_ is built when CUBE_SHIFTER_OE_EN is defined.
module cube_frame_shifter
    import cube_shift_pkg::*;
#(
    parameter int unsigned CTRL_BITS   = DEF_CTRL_BITS,
    parameter int unsigned COLOR_BITS  = DEF_COLOR_BITS,
    parameter int unsigned HALF_PERIOD = DEF_HALF_PERIOD,
    parameter int unsigned DWELL       = DEF_DWELL,
    parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                  master_clk,
    input  logic                  reset_,
    input  logic                  frame_valid,
    output logic                  frame_ready,
    input  logic [CTRL_BITS-1:0]  ctrl_data,
    input  logic [COLOR_BITS-1:0] red_data,
    input  logic [COLOR_BITS-1:0] green_data,
    input  logic [COLOR_BITS-1:0] blue_data,
    output logic                  Control_DS,
    output logic                  Control_SHCP,
    output logic                  RED_DS,
    output logic                  GREEN_DS,
    output logic                  BLUE_DS,
    output logic                  Color_SHCP,
    output logic                  STCP,
    output logic                  MR_,
    output logic                  busy,
    output logic                  frame_done
`ifdef CUBE_SHIFTER_OE_EN
    ,
    output logic                  OE_
`endif
);

    localparam int unsigned SLOT_LEN  = slot_len(HALF_PERIOD);
    localparam int unsigned COL_START = color_start(CTRL_BITS, COLOR_BITS);

    localparam logic [CNT_WIDTH-1:0] L_PH_LAST    = CNT_WIDTH'(SLOT_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] L_PH_RISE    = CNT_WIDTH'(HALF_PERIOD - 1);
    localparam logic [CNT_WIDTH-1:0] L_SLOT_LAST  = CNT_WIDTH'(CTRL_BITS - 1);
    localparam logic [CNT_WIDTH-1:0] L_COL_START  = CNT_WIDTH'(COL_START);
    localparam logic [CNT_WIDTH-1:0] L_LATCH_LAST = CNT_WIDTH'(HALF_PERIOD - 1);
    localparam logic [CNT_WIDTH-1:0] L_DWELL_LAST = CNT_WIDTH'((DWELL == 0) ? 0 : DWELL - 1);

    shift_state_t         r_state;
    logic [CNT_WIDTH-1:0] r_slot;
    logic [CNT_WIDTH-1:0] r_phase;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_ctrl_shcp;
    logic                 r_col_shcp;
    logic                 r_col_en;
    logic                 r_stcp;
    logic                 r_mr;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_slot_end;
    logic                 w_shift_ctrl;
    logic                 w_shift_col;
    logic [CNT_WIDTH-1:0] w_slot_nxt;
    logic                 w_ctrl_msb;
    logic                 w_red_msb;
    logic                 w_green_msb;
    logic                 w_blue_msb;

    assign w_accept     = (r_state == ST_IDLE) && r_ready && frame_valid;
    assign w_slot_end   = (r_state == ST_SHIFT) && (r_phase == L_PH_LAST);
    // The final slot never shifts so DS stays put through LATCH.
    assign w_shift_ctrl = w_slot_end && (r_slot != L_SLOT_LAST);
    assign w_shift_col  = w_shift_ctrl && r_col_en;
    assign w_slot_nxt   = r_slot + CNT_WIDTH'(1);

    shift_lane #(.WIDTH(CTRL_BITS)) u_ctrl_lane (
        .i_clk   (master_clk),
        .i_rst_n (reset_),
        .i_load  (w_accept),
        .i_shift (w_shift_ctrl),
        .i_data  (ctrl_data),
        .o_msb   (w_ctrl_msb)
    );

    shift_lane #(.WIDTH(COLOR_BITS)) u_red_lane (
        .i_clk   (master_clk),
        .i_rst_n (reset_),
        .i_load  (w_accept),
        .i_shift (w_shift_col),
        .i_data  (red_data),
        .o_msb   (w_red_msb)
    );

    shift_lane #(.WIDTH(COLOR_BITS)) u_green_lane (
        .i_clk   (master_clk),
        .i_rst_n (reset_),
        .i_load  (w_accept),
        .i_shift (w_shift_col),
        .i_data  (green_data),
        .o_msb   (w_green_msb)
    );

    shift_lane #(.WIDTH(COLOR_BITS)) u_blue_lane (
        .i_clk   (master_clk),
        .i_rst_n (reset_),
        .i_load  (w_accept),
        .i_shift (w_shift_col),
        .i_data  (blue_data),
        .o_msb   (w_blue_msb)
    );

    always_ff @(posedge master_clk or negedge reset_) begin
        if (!reset_) begin
            r_state     <= ST_IDLE;
            r_slot      <= '0;
            r_phase     <= '0;
            r_cnt       <= '0;
            r_ctrl_shcp <= 1'b0;
            r_col_shcp  <= 1'b0;
            r_col_en    <= 1'b0;
            r_stcp      <= 1'b0;
            r_mr        <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_mr   <= 1'b1;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state     <= ST_SHIFT;
                        r_slot      <= '0;
                        r_phase     <= '0;
                        r_ctrl_shcp <= 1'b0;
                        r_col_shcp  <= 1'b0;
                        r_col_en    <= (COL_START == 0);
                        r_ready     <= 1'b0;
                        r_busy      <= 1'b1;
                    end else begin
                        r_ready <= r_mr;
                    end
                end
                ST_SHIFT: begin
                    if (r_phase == L_PH_LAST) begin
                        r_phase     <= '0;
                        r_ctrl_shcp <= 1'b0;
                        r_col_shcp  <= 1'b0;
                        if (r_slot == L_SLOT_LAST) begin
                            r_state <= ST_LATCH;
                            r_cnt   <= '0;
                            r_stcp  <= 1'b1;
                        end else begin
                            r_slot <= w_slot_nxt;
                            if (w_slot_nxt == L_COL_START) begin
                                r_col_en <= 1'b1;
                            end
                        end
                    end else begin
                        r_phase <= r_phase + CNT_WIDTH'(1);
                        if (r_phase == L_PH_RISE) begin
                            r_ctrl_shcp <= 1'b1;
                            r_col_shcp  <= r_col_en;
                        end
                    end
                end
                ST_LATCH: begin
                    if (r_cnt == L_LATCH_LAST) begin
                        r_stcp <= 1'b0;
                        r_cnt  <= '0;
                        if (DWELL == 0) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= ST_DWELL;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                ST_DWELL: begin
                    if (r_cnt == L_DWELL_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef CUBE_SHIFTER_OE_EN
    logic r_oe;

    // Blank the LEDs while the chains are shifting and latching.
    always_ff @(posedge master_clk or negedge reset_) begin
        if (!reset_) begin
            r_oe <= 1'b1;
        end else if (r_state == ST_IDLE) begin
            r_oe <= w_accept;
        end else if ((r_state == ST_LATCH) && (r_cnt == L_LATCH_LAST)) begin
            r_oe <= 1'b0;
        end
    end

    assign OE_ = r_oe;
`endif

    assign Control_DS   = w_ctrl_msb;
    assign Control_SHCP = r_ctrl_shcp;
    assign RED_DS       = r_col_en & w_red_msb;
    assign GREEN_DS     = r_col_en & w_green_msb;
    assign BLUE_DS      = r_col_en & w_blue_msb;
    assign Color_SHCP   = r_col_shcp;
    assign STCP         = r_stcp;
    assign MR_          = r_mr;
    assign frame_ready  = r_ready;
    assign busy         = r_busy;
    assign frame_done   = r_done;

endmodule

// File: tb/tb_cube_frame_shifter.sv
// Scoreboard bench for cube_frame_shifter: default build plus a small fast configuration.
module tb_cube_frame_shifter;

    localparam int unsigned CB = 56, COLB = 8, HP = 4, DW = 1000;
    localparam int unsigned SHIFT_CYC    = CB * 2 * HP;
    localparam int unsigned PRE_COL      = 2 * HP * (CB - COLB);
    localparam int unsigned DONE_REL     = SHIFT_CYC + HP + DW + 1;
    localparam int unsigned COL_RISE_REL = 1 + PRE_COL + HP;

    localparam int unsigned SCB = 8, SCOL = 4, SHP = 1, SDW = 0;
    localparam int unsigned S_DONE_REL     = SCB * 2 * SHP + SHP + SDW + 1;
    localparam int unsigned S_COL_RISE_REL = 1 + 2 * SHP * (SCB - SCOL) + SHP;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          reset_;
    logic          frame_valid, frame_ready;
    logic [55:0]   ctrl_data;
    logic [7:0]    red_data, green_data, blue_data;
    logic          Control_DS, Control_SHCP, RED_DS, GREEN_DS, BLUE_DS, Color_SHCP;
    logic          STCP, MR_, busy, frame_done;

    logic          s_valid, s_ready;
    logic [7:0]    s_ctrl;
    logic [3:0]    s_red, s_green, s_blue;
    logic          s_cds, s_cshcp, s_rds, s_gds, s_bds, s_colshcp, s_stcp, s_mr, s_busy, s_done;
`ifdef CUBE_SHIFTER_OE_EN
    logic          OE_, s_oe;
`endif

    cube_frame_shifter dut (
        .master_clk(clk), .reset_(reset_), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .ctrl_data(ctrl_data), .red_data(red_data), .green_data(green_data), .blue_data(blue_data),
        .Control_DS(Control_DS), .Control_SHCP(Control_SHCP), .RED_DS(RED_DS), .GREEN_DS(GREEN_DS),
        .BLUE_DS(BLUE_DS), .Color_SHCP(Color_SHCP), .STCP(STCP), .MR_(MR_), .busy(busy),
        .frame_done(frame_done)
`ifdef CUBE_SHIFTER_OE_EN
        , .OE_(OE_)
`endif
    );

    cube_frame_shifter #(.CTRL_BITS(SCB), .COLOR_BITS(SCOL), .HALF_PERIOD(SHP), .DWELL(SDW),
                         .CNT_WIDTH(8)) dut_small (
        .master_clk(clk), .reset_(reset_), .frame_valid(s_valid), .frame_ready(s_ready),
        .ctrl_data(s_ctrl), .red_data(s_red), .green_data(s_green), .blue_data(s_blue),
        .Control_DS(s_cds), .Control_SHCP(s_cshcp), .RED_DS(s_rds), .GREEN_DS(s_gds),
        .BLUE_DS(s_bds), .Color_SHCP(s_colshcp), .STCP(s_stcp), .MR_(s_mr), .busy(s_busy),
        .frame_done(s_done)
`ifdef CUBE_SHIFTER_OE_EN
        , .OE_(s_oe)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [55:0] ctrl;
        logic [7:0]  r, g, b;
        int unsigned acc;
    } frame_t;

    frame_t sbq[$];

    // Monitor state: bits collected on each rising shift clock, pulse counts, event cycles.
    logic [55:0] m_ctrl;
    logic [7:0]  m_r, m_g, m_b;
    int unsigned m_ncs, m_ncol, m_stcp_hi, m_stcp_rise, m_first_cs, m_first_col, m_rel;
    logic        p_cs, p_col, p_stcp;
    frame_t      m_exp;

    task automatic mon_clear();
        m_ctrl = '0; m_r = '0; m_g = '0; m_b = '0;
        m_ncs = 0; m_ncol = 0; m_stcp_hi = 0; m_stcp_rise = 0;
        m_first_cs = 0; m_first_col = 0;
    endtask

    always @(negedge clk) begin
        if (!reset_) begin
            mon_clear();
            p_cs = 1'b0; p_col = 1'b0; p_stcp = 1'b0;
        end else begin
            m_rel = (sbq.size() != 0) ? cyc + 1 - sbq[0].acc : 0;
            if (Control_SHCP && !p_cs) begin
                m_ctrl = {m_ctrl[54:0], Control_DS};
                if (m_ncs == 0) m_first_cs = m_rel;
                m_ncs++;
            end
            if (Color_SHCP && !p_col) begin
                m_r = {m_r[6:0], RED_DS};
                m_g = {m_g[6:0], GREEN_DS};
                m_b = {m_b[6:0], BLUE_DS};
                if (m_ncol == 0) m_first_col = m_rel;
                m_ncol++;
            end
            if (sbq.size() != 0 && m_rel >= 1 && m_rel <= PRE_COL)
                chk("col_quiet", {RED_DS, GREEN_DS, BLUE_DS, Color_SHCP}, '0);
`ifdef CUBE_SHIFTER_OE_EN
            chk("oe_blank", OE_, (sbq.size() != 0 && m_rel >= 1 && m_rel <= SHIFT_CYC + HP));
`endif
            if (STCP) m_stcp_hi++;
            if (STCP && !p_stcp) begin
                m_stcp_rise++;
                chk("stcp_in_frame", sbq.size() != 0, 1'b1);
            end
            if (frame_done) begin
                chk("done_expected", sbq.size() != 0, 1'b1);
                if (sbq.size() != 0) begin
                    m_exp = sbq.pop_front();
                    chk("ctrl_bits", m_ctrl, m_exp.ctrl);
                    chk("ctrl_edges", m_ncs, CB);
                    chk("first_ctrl_rise", m_first_cs, 1 + HP);
                    chk("red_bits", m_r, m_exp.r);
                    chk("green_bits", m_g, m_exp.g);
                    chk("blue_bits", m_b, m_exp.b);
                    chk("col_edges", m_ncol, COLB);
                    chk("first_col_rise", m_first_col, COL_RISE_REL);
                    chk("stcp_pulses", m_stcp_rise, 1);
                    chk("stcp_width", m_stcp_hi, HP);
                    chk("done_cycle", m_rel, DONE_REL);
                    chk("ready_at_done", frame_ready, 1'b1);
                    chk("busy_at_done", busy, 1'b0);
                end
                mon_clear();
            end
            p_cs = Control_SHCP; p_col = Color_SHCP; p_stcp = STCP;
        end
    end

    task automatic send(input logic [55:0] c, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input bit hold, input bit b2b);
        int unsigned n;
        frame_t f;
        frame_valid = 1'b1;
        ctrl_data = c; red_data = r; green_data = g; blue_data = b;
        n = 0;
        while (!frame_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", frame_ready, 1'b1);
        if (frame_ready) begin
            if (b2b) chk("b2b_on_done", frame_done, 1'b1);
            f.ctrl = c; f.r = r; f.g = g; f.b = b; f.acc = cyc + 1;
            sbq.push_back(f);
            @(negedge clk);
        end
        if (!hold) frame_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (sbq.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sbq.size(), 0);
    endtask

    task automatic do_reset();
        reset_ = 1'b0;
        #1;
        chk("rst_async_outs", {Control_DS, Control_SHCP, RED_DS, GREEN_DS, BLUE_DS, Color_SHCP,
                               STCP, MR_, frame_ready, busy, frame_done}, '0);
`ifdef CUBE_SHIFTER_OE_EN
        chk("rst_oe", OE_, 1'b1);
`endif
        sbq.delete();
        repeat (3) @(negedge clk);
        reset_ = 1'b1;
        chk("mr_held_low", MR_, 1'b0);
        @(posedge clk); #1;
        chk("mr_release", MR_, 1'b1);
        chk("ready_one_late", frame_ready, 1'b0);
        @(posedge clk); #1;
        chk("ready_release", frame_ready, 1'b1);
        chk("idle_outs", {Control_DS, Control_SHCP, RED_DS, GREEN_DS, BLUE_DS, Color_SHCP,
                          STCP, busy, frame_done}, '0);
        @(negedge clk);
    endtask

    logic [63:0] rnd;
    logic [7:0]  s_cbits;
    logic [3:0]  s_rbits, s_gbits, s_bbits;
    int unsigned s_acc, s_rel, s_done_rel, s_first_col, s_stcp_hi, n;
    logic        sp_cs, sp_col;

    initial begin
        reset_ = 1'b0;
        frame_valid = 1'b0; ctrl_data = '0; red_data = '0; green_data = '0; blue_data = '0;
        s_valid = 1'b0; s_ctrl = '0; s_red = '0; s_green = '0; s_blue = '0;
        repeat (2) @(negedge clk);
        do_reset();

        // Small configuration: no dwell, single-cycle half period.
        s_valid = 1'b1; s_ctrl = 8'hB4; s_red = 4'h9; s_green = 4'h6; s_blue = 4'h3;
        n = 0;
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("s_accept", s_ready, 1'b1);
        s_acc = cyc + 1;
        @(negedge clk);
        s_valid = 1'b0;
        s_cbits = '0; s_rbits = '0; s_gbits = '0; s_bbits = '0;
        s_done_rel = 0; s_first_col = 0; s_stcp_hi = 0; sp_cs = 1'b0; sp_col = 1'b0;
        for (int k = 0; k < 40 && s_done_rel == 0; k++) begin
            s_rel = cyc + 1 - s_acc;
            if (s_cshcp && !sp_cs) s_cbits = {s_cbits[6:0], s_cds};
            if (s_colshcp && !sp_col) begin
                if (s_first_col == 0) s_first_col = s_rel;
                s_rbits = {s_rbits[2:0], s_rds};
                s_gbits = {s_gbits[2:0], s_gds};
                s_bbits = {s_bbits[2:0], s_bds};
            end
            if (s_stcp) s_stcp_hi++;
            if (s_done) begin
                s_done_rel = s_rel;
                chk("s_busy_at_done", s_busy, 1'b0);
                chk("s_mr_at_done", s_mr, 1'b1);
`ifdef CUBE_SHIFTER_OE_EN
                chk("s_oe_at_done", s_oe, 1'b0);
`endif
            end
            sp_cs = s_cshcp; sp_col = s_colshcp;
            @(negedge clk);
        end
        chk("s_done_cycle", s_done_rel, S_DONE_REL);
        chk("s_ctrl_bits", s_cbits, 8'hB4);
        chk("s_rgb_bits", {s_rbits, s_gbits, s_bbits}, 12'h963);
        chk("s_first_col_rise", s_first_col, S_COL_RISE_REL);
        chk("s_stcp_width", s_stcp_hi, SHP);

        // Directed frame from the bring-up pattern.
        send(56'h80_0000_0000_0001, 8'hA5, 8'h00, 8'hFF, 1'b0, 1'b0);
        drain();

        // Back-to-back random frames with frame_valid held high.
        for (int i = 0; i < 4; i++) begin
            rnd = {$urandom(), $urandom()};
            send(rnd[55:0], 8'($urandom()), 8'($urandom()), 8'($urandom()), (i < 3), (i > 0));
        end
        drain();

        // Random gap then another frame.
        repeat ($urandom_range(1, 20)) @(negedge clk);
        rnd = {$urandom(), $urandom()};
        send(rnd[55:0], 8'($urandom()), 8'($urandom()), 8'($urandom()), 1'b0, 1'b0);
        drain();

        // Reset in the middle of SHIFT: the in-flight frame must vanish without a latch.
        rnd = {$urandom(), $urandom()};
        send(rnd[55:0], 8'($urandom()), 8'($urandom()), 8'($urandom()), 1'b0, 1'b0);
        repeat (199) @(negedge clk);
        chk("mid_reset_busy", busy, 1'b1);
        do_reset();
        repeat (1600) @(negedge clk);
        rnd = {$urandom(), $urandom()};
        send(rnd[55:0], 8'($urandom()), 8'($urandom()), 8'($urandom()), 1'b0, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cube_frame_shifter.md
# cube_frame_shifter

Downstream output stage of the LED-cube scanning path. Accepts one plane frame per valid/ready handshake: a control word for the control '595 chain plus red/green/blue bytes. Serialises the frame onto the 74HC595 pins (DS/SHCP per chain, shared STCP and MR_), then holds the latched image for a programmable dwell before accepting the next frame. Pattern sequencers upstream present frames here instead of bit-banging the pins themselves.

## Interface
- CTRL_BITS, 56: control-chain length in bits (7 lines x 8).
- COLOR_BITS, 8: length of each colour chain; must be <= CTRL_BITS.
- HALF_PERIOD, 4: master_clk cycles per SHCP/STCP half-period; must be >= 1.
- DWELL, 1000: master_clk cycles the latched frame is held; 0 allowed.
- CNT_WIDTH, 16: width of the slot/dwell counters; must hold max(CTRL_BITS, 2*HALF_PERIOD, DWELL).

- master_clk  in  1  sole clock; everything updates on its rising edge.
- reset_  in  1  asynchronous, active-low reset.
- frame_valid  in  1  upstream frame present.
- frame_ready  out  1  high only in IDLE with MR_ high.
- ctrl_data  in  CTRL_BITS  control word, MSB shifted first.
- red_data / green_data / blue_data  in  COLOR_BITS each  colour bytes, MSB first.
- Control_DS, Control_SHCP  out  1  control chain serial data / shift clock.
- RED_DS, GREEN_DS, BLUE_DS  out  1  colour serial data.
- Color_SHCP  out  1  shift clock shared by the three colour chains.
- STCP  out  1  storage-register latch, shared.
- MR_  out  1  '595 master reset, active-low.
- busy  out  1  high in SHIFT, LATCH, DWELL.
- frame_done  out  1  one-cycle pulse at end of dwell.

## Operation
- States: IDLE -> SHIFT -> LATCH -> DWELL -> IDLE. If DWELL==0, LATCH -> IDLE.
- Accept: frame_valid && frame_ready on a clock edge. All data inputs are captured into internal lanes. Inputs are ignored at all other times.
- SHIFT: CTRL_BITS bit slots of 2*HALF_PERIOD cycles each.
  - In each slot, DS changes at slot start. SHCP is low for the first HALF_PERIOD cycles and high for the second.
  - Colour lanes are right-aligned: their DS/Color_SHCP activity occupies only the final COLOR_BITS slots. Color_SHCP stays low and colour DS stays 0 before that.
  - Both chains complete on the same slot.
- LATCH: all SHCP low, DS held. STCP high for HALF_PERIOD cycles.
- DWELL: STCP low; counter runs DWELL cycles. frame_done pulses on the transition to IDLE.
- frame_ready is low in every state except IDLE; there is no back-to-back acceptance inside a frame.
- Reset values: all DS/SHCP/STCP 0, MR_ 0, frame_ready 0, busy 0, frame_done 0, state IDLE.
- MR_ is low asynchronously while reset_ is low, and rises on the first master_clk edge after release.
- Reset mid-frame: outputs take reset values immediately and the in-flight frame is discarded. Upstream must re-present it.
- frame_valid held high during busy: no effect, no capture.

## Timing
- Acceptance edge = cycle 0. First SHCP low phase with first DS bit occupies cycles 1..HALF_PERIOD.
- SHIFT spans CTRL_BITS*2*HALF_PERIOD cycles: 448 at defaults.
- LATCH spans HALF_PERIOD cycles: 4.
- frame_done and frame_ready rise in cycle CTRL_BITS*2*HALF_PERIOD + HALF_PERIOD + DWELL + 1: cycle 1453 at defaults.
- Next acceptance is possible that same edge if frame_valid is high.
- Counters wrap only by explicit reload; no free-running rollover.

## Configuration
- CUBE_SHIFTER_OE_EN defined:
  - Adds output OE_ (1 bit, active-low output enable).
  - OE_ is high (blanked) in SHIFT and LATCH, low in DWELL and IDLE, and high during reset.
  - This suppresses ghosting while the chains shift.
- Undefined: no OE_ port; '595 OE pins are tied low externally.

## Structure
- Package cube_shift_pkg:
  - state enum (IDLE, SHIFT, LATCH, DWELL);
  - localparam helpers for slot length and the colour start slot (CTRL_BITS-COLOR_BITS).
- Sub-module shift_lane: parallel-load, MSB-out shift register with load and shift strobes, parameterised width. Instantiated four times (control, red, green, blue).
- The FSM and slot/phase/dwell counters live in cube_frame_shifter.

## Test plan
- Reset release: MR_ 0 -> 1 one cycle after reset_ rises; frame_ready 1 next cycle; all DS/SHCP/STCP 0.
- Single frame, defaults, ctrl_data=56'h80_0000_0000_0001, red=8'hA5, green=8'h00, blue=8'hFF:
  - 56 Control_SHCP rising edges; Control_DS samples 1, then 54 zeros, then 1;
  - 8 Color_SHCP edges, starting at slot 48; RED_DS samples 1,0,1,0,0,1,0,1;
  - one STCP pulse 4 cycles wide; frame_done in cycle 1453.
- Back-to-back: frame_valid held high with two frames; second accepted exactly on the frame_done cycle; no STCP between frames other than one per frame.
- Reset asserted at cycle 200 mid-SHIFT: all outputs 0 and MR_ 0 within the same cycle; after release, no STCP occurs until a new frame completes.
- DWELL=0, HALF_PERIOD=1, CTRL_BITS=8: LATCH goes directly to IDLE; frame_done in cycle 18.
- With CUBE_SHIFTER_OE_EN: OE_ high from cycle 1 to end of LATCH, low during DWELL.
